// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the single-port data memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        VGA_RD = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_CPU  = 2'd1,
        G_VGA  = 2'd2
    } grant_t;

    localparam int PIX_W      = 24;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_arbiter_pix_fifo.sv
// Synchronous pixel FIFO: registered storage, combinational head, flush keeps the head slot.
module pix_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && !full && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // Collapse onto the read pointer so the visible head does not move.
            r_wr_ptr <= r_rd_ptr;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates one synchronous-read dmem port between the CPU and a prefetching VGA pixel FIFO.
// Optional DMEM_ARB_STATS_EN adds saturating wait/underflow statistics outputs.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 8,
    parameter int                LOW_WM     = 2,
    parameter logic [ADDR_W-1:0] FB_BASE    = ADDR_W'(32'h0000_1000),
    parameter int unsigned       FB_WORDS   = 307200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underflow,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_wait,
    output logic [15:0]       stat_underflows
`endif
);

    localparam int                CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] FB_END = FB_BASE + ADDR_W'(WORD_BYTES * FB_WORDS);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    grant_t            w_grant;
    logic [ADDR_W-1:0] r_fetch_ptr;
    logic [ADDR_W-1:0] w_fetch_inc;
    logic [ADDR_W-1:0] w_fetch_nxt;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_underflow;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_level;
    logic              w_empty;
    logic              w_full;
    logic              w_vga_inflight;
    logic              w_cpu_return;
    logic              w_push;
    logic              w_urgent;
    logic              w_has_room;
    logic              w_cpu_eligible;

    assign w_vga_inflight = (r_state == VGA_RD);
    assign w_cpu_return   = (r_state == CPU_RD) && !reset;
    assign w_level        = {1'b0, w_count} + {{CNT_W{1'b0}}, w_vga_inflight};
    assign w_urgent       = (int'(w_level) < LOW_WM);
    assign w_has_room     = (int'(w_level) < FIFO_DEPTH);
    // During a CPU read's return cycle cpu_req still belongs to the request being acked.
    assign w_cpu_eligible = cpu_req && (r_state != CPU_RD);

    always_comb begin
        w_grant = G_NONE;
        if (!reset) begin
            if (w_urgent && !frame_start) begin
                w_grant = G_VGA;
            end else if (w_cpu_eligible) begin
                w_grant = G_CPU;
            end else if (w_has_room && !frame_start) begin
                w_grant = G_VGA;
            end
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (w_grant == G_VGA) begin
            w_state_nxt = VGA_RD;
        end else if ((w_grant == G_CPU) && !cpu_we) begin
            w_state_nxt = CPU_RD;
        end
    end

    assign w_fetch_inc = r_fetch_ptr + STEP;
    assign w_fetch_nxt = (w_fetch_inc == FB_END) ? FB_BASE : w_fetch_inc;

    always_comb begin
        mem_addr = '0;
        case (w_grant)
            G_CPU:   mem_addr = cpu_addr;
            G_VGA:   mem_addr = r_fetch_ptr;
            default: mem_addr = '0;
        endcase
    end

    assign mem_en    = (w_grant != G_NONE);
    assign mem_we    = (w_grant == G_CPU) && cpu_we;
    assign mem_wdata = mem_we ? cpu_wdata : '0;

    assign cpu_ack   = w_cpu_return || mem_we;
    assign cpu_rdata = w_cpu_return ? mem_rdata : r_cpu_rdata;

    // A VGA word returning in a frame_start cycle belongs to the old frame and is dropped.
    assign w_push = w_vga_inflight && !frame_start && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_fetch_ptr <= FB_BASE;
            r_cpu_rdata <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (frame_start) begin
                r_fetch_ptr <= FB_BASE;
            end else if (w_grant == G_VGA) begin
                r_fetch_ptr <= w_fetch_nxt;
            end
            if (w_cpu_return) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (pix_pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_pix_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (pix_pop),
        .flush (frame_start),
        .din   (mem_rdata[PIX_W-1:0]),
        .dout  (pix_data),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    assign pix_valid = !w_empty;
    assign underflow = r_underflow;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_stat_cpu_wait;
    logic [15:0] r_stat_underflows;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            r_stat_cpu_wait   <= '0;
            r_stat_underflows <= '0;
        end else begin
            if (w_cpu_eligible && (w_grant != G_CPU)) begin
                r_stat_cpu_wait <= sat_inc16(r_stat_cpu_wait);
            end
            if (pix_pop && w_empty) begin
                r_stat_underflows <= sat_inc16(r_stat_underflows);
            end
        end
    end

    assign stat_cpu_wait   = r_stat_cpu_wait;
    assign stat_underflows = r_stat_underflows;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model with queue FIFO, plus a small-frame wrap instance.
module tb_dmem_arbiter;

    localparam logic [31:0] FB     = 32'h0000_1000;
    localparam int          DEPTH  = 8;
    localparam int          LWM    = 2;
    localparam int          WORDS1 = 307200;
    localparam int          WORDS2 = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cpu_req, cpu_we, frame_start, pix_pop;
    logic [31:0] cpu_addr, cpu_wdata;

    logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, pix_valid, underflow, mem_en, mem_we;
    logic [23:0] pix_data;

    logic [31:0] cpu_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
    logic        cpu_ack2, pix_valid2, underflow2, mem_en2, mem_we2;
    logic [23:0] pix_data2;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] st_wait1, st_uf1, st_wait2, st_uf2;
`endif

    dmem_arbiter #(.FB_WORDS(WORDS1)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .frame_start(frame_start), .pix_pop(pix_pop), .pix_data(pix_data),
        .pix_valid(pix_valid), .underflow(underflow), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_cpu_wait(st_wait1), .stat_underflows(st_uf1)
`endif
    );

    dmem_arbiter #(.FB_WORDS(WORDS2)) dut2 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata2), .cpu_ack(cpu_ack2),
        .frame_start(frame_start), .pix_pop(pix_pop), .pix_data(pix_data2),
        .pix_valid(pix_valid2), .underflow(underflow2), .mem_en(mem_en2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
`ifdef DMEM_ARB_STATS_EN
        , .stat_cpu_wait(st_wait2), .stat_underflows(st_uf2)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int unsigned idx);
        return 32'hA500_0000 | (idx << 2);
    endfunction

    // Memories (one per DUT) and the model's shadow copy, word-indexed by addr[15:2].
    logic [31:0] mem1   [16384];
    logic [31:0] mem2   [16384];
    logic [31:0] shadow [16384];

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem1[i]   = pat(i);
            mem2[i]   = pat(i);
            shadow[i] = pat(i);
        end
        mem1[32'h80 >> 2]   = 32'h1234_5678;
        mem2[32'h80 >> 2]   = 32'h1234_5678;
        shadow[32'h80 >> 2] = 32'h1234_5678;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem1[mem_addr[15:2]] <= mem_wdata;
            else        mem_rdata <= mem1[mem_addr[15:2]];
        end
        if (mem_en2) begin
            if (mem_we2) mem2[mem_addr2[15:2]] <= mem_wdata2;
            else         mem_rdata2 <= mem2[mem_addr2[15:2]];
        end
    end

    // Transaction-level model: FIFO as a queue, one outstanding read described by kind+address.
    logic [23:0] mq[$];
    int          pend;        // 0 none, 1 CPU read, 2 VGA read
    logic [31:0] pend_addr;
    int          fidx;
    logic        uf_m;
    logic [31:0] hold_m;
    logic        ack_q;
    int          m_lvl, m_g;
    logic [31:0] m_ea, m_rv, m_erd;
    logic        m_en, m_we, m_ack;

    always @(negedge clk) begin
        ack_q = cpu_ack;
        if (reset) begin
            mq.delete();
            pend = 0; pend_addr = '0; fidx = 0; uf_m = 1'b0; hold_m = '0;
        end else begin
            m_lvl = mq.size() + ((pend == 2) ? 1 : 0);
            m_g = 0;
            if (m_lvl < LWM && !frame_start)            m_g = 2;
            else if (cpu_req && pend != 1)              m_g = 1;
            else if (m_lvl < DEPTH && !frame_start)     m_g = 2;
            m_ea  = (m_g == 2) ? (FB + 32'(4 * fidx)) : cpu_addr;
            m_en  = (m_g != 0);
            m_we  = (m_g == 1) && cpu_we;
            m_rv  = shadow[pend_addr[15:2]];
            m_ack = (pend == 1) || m_we;
            m_erd = (pend == 1) ? m_rv : hold_m;

            check("mem_en", 32'(mem_en), 32'(m_en));
            check("mem_we", 32'(mem_we), 32'(m_we));
            if (m_en) check("mem_addr", mem_addr, m_ea);
            if (m_we) check("mem_wdata", mem_wdata, cpu_wdata);
            check("cpu_ack", 32'(cpu_ack), 32'(m_ack));
            check("cpu_rdata", cpu_rdata, m_erd);
            check("pix_valid", 32'(pix_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) check("pix_data", 32'(pix_data), 32'(mq[0]));
            check("underflow", 32'(underflow), 32'(uf_m));

            if (pix_pop && mq.size() == 0) uf_m = 1'b1;
            if (frame_start) begin
                mq.delete();
            end else begin
                if (pix_pop && mq.size() > 0) void'(mq.pop_front());
                if (pend == 2) mq.push_back(m_rv[23:0]);
            end
            if (pend == 1) hold_m = m_rv;
            if (m_we) shadow[cpu_addr[15:2]] = cpu_wdata;
            if (m_g == 2) begin
                pend = 2; pend_addr = m_ea; fidx = (fidx + 1) % WORDS1;
            end else if (m_g == 1 && !cpu_we) begin
                pend = 1; pend_addr = cpu_addr;
            end else begin
                pend = 0;
            end
            if (frame_start) fidx = 0;
        end
    end

    // Small-frame instance: the k-th fetch after frame start must be FB + 4*(k mod 4).
    int k2;
    always @(negedge clk) begin
        if (reset) begin
            k2 = 0;
        end else begin
            if (mem_en2 && !mem_we2 && mem_addr2 >= FB) begin
                check("wrap_addr", mem_addr2, FB + 32'(4 * (k2 % WORDS2)));
                k2++;
            end
            if (frame_start) k2 = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog");
    end

    int served;

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        frame_start = 1'b0; pix_pop = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("fill_en", 32'(mem_en), 32'd1);
            check("fill_addr", mem_addr, 32'h1000 + 32'(4 * i));
            tick();
        end
        @(negedge clk);
        check("fill_stop", 32'(mem_en), 32'd0);
        check("fill_valid", 32'(pix_valid), 32'd1);
        check("fill_head", 32'(pix_data), 32'h0000_1000);
        repeat (3) tick();

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", mem_addr, 32'h40);
        check("wr_data", mem_wdata, 32'hDEAD_BEEF);
        check("wr_ack", 32'(cpu_ack), 32'd1);
        tick();
        cpu_we = 1'b0; cpu_addr = 32'h80;
        @(negedge clk);
        check("rd_issue_addr", mem_addr, 32'h80);
        check("rd_issue_noack", 32'(cpu_ack), 32'd0);
        tick();
        @(negedge clk);
        check("rd_ack", 32'(cpu_ack), 32'd1);
        check("rd_data", cpu_rdata, 32'h1234_5678);
        check("rd_no_reissue", 32'(mem_en), 32'd0);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        check("rd_hold", cpu_rdata, 32'h1234_5678);
        check("rd_ack_drop", 32'(cpu_ack), 32'd0);

        tick();
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        @(negedge clk);
        check("refill_addr", mem_addr, 32'h1020);
        tick();
        frame_start = 1'b1;
        @(negedge clk);
        check("fs_no_issue", 32'(mem_en), 32'd0);
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        check("fs_restart_addr", mem_addr, 32'h1000);
        check("fs_flushed", 32'(pix_valid), 32'd0);
        tick();
        @(negedge clk);
        check("fs_discard_empty", 32'(pix_valid), 32'd0);
        tick();
        @(negedge clk);
        check("fs_first_pix", 32'(pix_data), 32'h0000_1000);

        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        @(negedge clk);
        check("urgent_vga_addr", mem_addr, 32'h1000);
        served = -1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            @(negedge clk);
            if (mem_en && !mem_we && mem_addr == 32'h80) begin
                served = k;
                break;
            end
        end
        check("cpu_serve_delay", 32'(served), 32'd2);
        tick();
        @(negedge clk);
        check("starve_rd_ack", 32'(cpu_ack), 32'd1);
        check("starve_rd_data", cpu_rdata, 32'h1234_5678);
        tick();
        cpu_req = 1'b0;

        frame_start = 1'b1; pix_pop = 1'b1;
        repeat (9) tick();
        @(negedge clk);
        check("uf_set", 32'(underflow), 32'd1);
        check("uf_empty", 32'(pix_valid), 32'd0);
        tick();
        frame_start = 1'b0; pix_pop = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("uf_sticky", 32'(underflow), 32'd1);

        repeat (12) tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        @(negedge clk);
        check("mid_rst_issue", mem_addr, 32'h100);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_no_ack", 32'(cpu_ack), 32'd0);
        tick();
        reset = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("post_rst_uf", 32'(underflow), 32'd0);
        check("post_rst_addr", mem_addr, 32'h1000);

        for (int c = 0; c < 3000; c++) begin
            tick();
            if (cpu_req && ack_q) cpu_req = 1'b0;
            if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 32'($urandom_range(0, 1023)) << 2;
                cpu_wdata = $urandom;
            end
            pix_pop     = ($urandom_range(0, 1) == 1);
            frame_start = ($urandom_range(0, 199) == 0);
        end
        tick();
        cpu_req = 1'b0; pix_pop = 1'b0; frame_start = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported synchronous-read data memory between two requesters: the CPU data port and the VGA pixel fetcher.
- Prefetches framebuffer words into a small pixel FIFO so scanout never waits on the CPU.
- Sits between the processor/vga_top and dmem.
- Replaces the dual-port dmem scheme with an arbitrated single port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, memory word width.
- FIFO_DEPTH, 8, pixel FIFO entries (power of 2, ≥4).
- LOW_WM, 2, urgent threshold: VGA gets priority when occupancy plus in-flight reads is below this value.
- FB_BASE, 32'h0000_1000, framebuffer byte base address.
- FB_WORDS, 307200, pixels per frame (one word per pixel).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- frame_start  in  1  one-cycle pulse at the start of each frame
- pix_pop  in  1  VGA consumes the FIFO head
- pix_data  out  24  FIFO head pixel (mem word [23:0])
- pix_valid  out  1  FIFO not empty
- underflow  out  1  sticky flag: a pop occurred while the FIFO was empty
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read issue

Behaviour:
- Reset values:
  - cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata, pix_valid, pix_data, underflow: all 0.
  - FIFO empty; fetch pointer = FB_BASE; FSM in IDLE.
- Memory timing:
  - Read issued in cycle N returns mem_rdata in N+1.
  - Write completes in its issue cycle.
  - At most one read is in flight.
- FSM states: IDLE, CPU_RD, VGA_RD.
  - IDLE: issue at most one access per cycle.
  - CPU_RD: capture mem_rdata, then return to IDLE.
  - VGA_RD: capture mem_rdata, then return to IDLE.
- Grant rule, evaluated in IDLE and in the return cycle of CPU_RD/VGA_RD, so back-to-back issue is allowed:
  1. If (count + inflight) < LOW_WM and not in the frame_start cycle → VGA read.
  2. Else if cpu_req → CPU access.
  3. Else if (count + inflight) < FIFO_DEPTH → VGA read.
  4. Else no access.
- CPU write: cpu_ack in the issue cycle; no state change.
- CPU read: cpu_ack and cpu_rdata in N+1; cpu_rdata holds until the next read ack.
- VGA read:
  - Pushes mem_rdata into the FIFO in N+1.
  - Fetch pointer += 4 at issue.
  - When the pointer reaches FB_BASE + 4*FB_WORDS, it wraps to FB_BASE.
- FIFO:
  - pix_data shows the head combinationally from registered storage.
  - Push and pop in the same cycle leave count unchanged.
  - Push never occurs when full; the grant rule guarantees this.
- Pop while empty: sets underflow (sticky until reset); pix_data holds its value; count stays 0.
- frame_start:
  - Flushes the FIFO and sets the fetch pointer to FB_BASE.
  - An in-flight VGA read is discarded, not pushed.
  - No VGA issue in that cycle.
  - An in-flight CPU read completes normally.
- Reset mid-transaction: the in-flight read is abandoned; no cpu_ack is emitted.
- CPU starvation bound: once the FIFO is at or above LOW_WM, the CPU is served within 2 cycles.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output stat_cpu_wait, 16 bits: counts cycles with cpu_req=1 and no grant; saturates at 16'hFFFF.
  - Adds output stat_underflows, 16 bits: counts underflow pops; saturating.
  - Both counters clear on reset and on frame_start.
- Undefined: neither port nor either counter exists; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_t enum (IDLE, CPU_RD, VGA_RD).
  - grant_t enum (G_NONE, G_CPU, G_VGA).
  - PIX_W = 24.
  - WORD_BYTES = 4.
- One sub-module: pix_fifo (synchronous FIFO with push, pop, flush, count, empty, full).

Test Plan:
- Reset, then idle with no pops: FIFO fills to 8 via consecutive reads at 0x1000, 0x1004, … 0x101C; mem_en then drops; pix_valid=1; pix_data = mem[0x1000][23:0].
- CPU write 0xDEADBEEF to 0x40 with FIFO full: mem_we=1 with addr 0x40 in the same cycle; cpu_ack pulses that cycle.
- CPU read of 0x80 holding 0x12345678, FIFO full: cpu_ack and cpu_rdata = 0x12345678 exactly one cycle after issue.
- FIFO count 1 with cpu_req asserted: the VGA read is granted first; the CPU is served at most 2 cycles later.
- Pop 8 times while the FIFO is empty after frame_start: underflow=1 and stays 1; pix_valid=0.
- frame_start asserted while a VGA read is in flight: that word is not pushed; the next issued address is 0x1000.
- FB_WORDS=4 with 10 pops: addresses sequence 0x1000, 0x1004, 0x1008, 0x100C, 0x1000, …
